// File: rtl/imm_gen_pkg.sv
// Shared constants for the immediate/branch pipeline: mode and modifier encodings,
// default widths.
package imm_gen_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned IMM_W_DEF = 18;
    localparam int unsigned OFF_W_DEF = 27;
    localparam int unsigned INSN_W    = 32;
    localparam int unsigned IMM16_W   = 16;

    localparam logic MODE_LEGACY = 1'b0;
    localparam logic MODE_MOD    = 1'b1;

    typedef enum logic [1:0] {
        MOD_DEFAULT = 2'b00,
        MOD_U       = 2'b01,
        MOD_H       = 2'b10,
        MOD_RSVD    = 2'b11
    } mod_e;

endpackage

// File: rtl/imm_branch_pipe_if.sv
// Handshake and payload bundle for imm_branch_pipe. Optional target_ovf is present
// only when IMMGEN_OVERFLOW_CHECK_EN is defined.
interface imm_branch_pipe_if #(
    parameter int unsigned XLEN = imm_gen_pkg::XLEN_DEF
);
    logic                           in_valid;
    logic                           in_ready;
    logic [XLEN-1:0]                pc;
    logic [imm_gen_pkg::INSN_W-1:0] instruction;
    logic                           mode;
    logic                           flush;
    logic                           out_valid;
    logic                           out_ready;
    logic [XLEN-1:0]                immx;
    logic [XLEN-1:0]                branch_target;
    logic [XLEN-1:0]                ret_addr;
`ifdef IMMGEN_OVERFLOW_CHECK_EN
    logic                           target_ovf;
`endif

    modport master (
        output in_valid, pc, instruction, mode, flush, out_ready,
`ifdef IMMGEN_OVERFLOW_CHECK_EN
        input  target_ovf,
`endif
        input  in_ready, out_valid, immx, branch_target, ret_addr
    );

    modport slave (
        input  in_valid, pc, instruction, mode, flush, out_ready,
`ifdef IMMGEN_OVERFLOW_CHECK_EN
        output target_ovf,
`endif
        output in_ready, out_valid, immx, branch_target, ret_addr
    );

endinterface

// File: rtl/imm_extend.sv
// Combinational immediate extender: legacy IMM_W-bit sign-extend or 16-bit
// modifier-driven decode (signed / unsigned / high-half).
module imm_extend
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned IMM_W = IMM_W_DEF
) (
    input  logic [INSN_W-1:0] instruction,
    input  logic              mode,
    output logic [XLEN-1:0]   immx_c
);

    logic [IMM16_W-1:0] imm16_c;
    mod_e               mod_c;
    logic               unused_insn_c;

    assign imm16_c       = instruction[IMM16_W-1:0];
    assign mod_c         = mod_e'(instruction[17:16]);
    assign unused_insn_c = ^instruction;

    always_comb begin
        immx_c = XLEN'($signed(imm16_c));
        if (mode == MODE_LEGACY) begin
            immx_c = XLEN'($signed(instruction[IMM_W-1:0]));
        end else begin
            unique case (mod_c)
                MOD_U:   immx_c = XLEN'(imm16_c);
                MOD_H:   immx_c = XLEN'({imm16_c, 16'h0000});
                default: immx_c = XLEN'($signed(imm16_c));
            endcase
        end
    end

endmodule

// File: rtl/imm_branch_pipe.sv
// Two-stage immediate-extend / branch-target pipeline with valid-ready flow control
// and flush. Define IMMGEN_OVERFLOW_CHECK_EN to add the registered target_ovf flag.
module imm_branch_pipe
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned IMM_W = IMM_W_DEF,
    parameter int unsigned OFF_W = OFF_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    imm_branch_pipe_if.slave  bus
);

    logic             s1_valid;
    logic [XLEN-1:0]  s1_pc;
    logic [XLEN-1:0]  s1_immx;
    logic [OFF_W-1:0] s1_off;

    logic [XLEN-1:0]  immx_c;
    logic             s2_ready_c;
    logic             s1_move_c;
    logic             accept_c;
    logic [XLEN-1:0]  target_c;
    logic [XLEN-1:0]  ret_c;

    imm_extend #(
        .XLEN  (XLEN),
        .IMM_W (IMM_W)
    ) u_extend (
        .instruction (bus.instruction),
        .mode        (bus.mode),
        .immx_c      (immx_c)
    );

    // in_ready reads 1 during flush since any offered entry is simply dropped
    assign s2_ready_c   = !bus.out_valid || bus.out_ready;
    assign s1_move_c    = s1_valid && s2_ready_c;
    assign bus.in_ready = bus.flush || !s1_valid || s1_move_c;
    assign accept_c     = bus.in_valid && bus.in_ready && !bus.flush;

    assign target_c = s1_pc + (XLEN'($signed(s1_off)) << 2);
    assign ret_c    = s1_pc + XLEN'(4);

    // S1: extended immediate, pc and raw offset field
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_pc    <= '0;
            s1_immx  <= '0;
            s1_off   <= '0;
        end else if (bus.flush) begin
            s1_valid <= 1'b0;
        end else if (accept_c) begin
            s1_valid <= 1'b1;
            s1_pc    <= bus.pc;
            s1_immx  <= immx_c;
            s1_off   <= bus.instruction[OFF_W-1:0];
        end else if (s1_move_c) begin
            s1_valid <= 1'b0;
        end
    end

    // S2: registered results, held while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid     <= 1'b0;
            bus.immx          <= '0;
            bus.branch_target <= '0;
            bus.ret_addr      <= '0;
        end else if (bus.flush) begin
            bus.out_valid <= 1'b0;
        end else if (s1_move_c) begin
            bus.out_valid     <= 1'b1;
            bus.immx          <= s1_immx;
            bus.branch_target <= target_c;
            bus.ret_addr      <= ret_c;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

`ifdef IMMGEN_OVERFLOW_CHECK_EN
    localparam int unsigned EXT_W = XLEN + 2;
    localparam int unsigned RET_W = XLEN + 1;

    logic [EXT_W-1:0] tgt_wide_c;
    logic [RET_W-1:0] ret_wide_c;
    logic             ovf_c;

    // Top two bits of the widened signed sum flag both wrap directions
    assign tgt_wide_c = {2'b00, s1_pc} + (EXT_W'($signed(s1_off)) << 2);
    assign ret_wide_c = {1'b0, s1_pc} + RET_W'(4);
    assign ovf_c      = tgt_wide_c[EXT_W-1] || tgt_wide_c[EXT_W-2] || ret_wide_c[RET_W-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.target_ovf <= 1'b0;
        end else if (!bus.flush && s1_move_c) begin
            bus.target_ovf <= ovf_c;
        end
    end
`endif

endmodule

// File: tb/tb_imm_branch_pipe.sv
// Self-checking bench for imm_branch_pipe: directed scenarios plus randomized traffic
// against a queue-based arithmetic reference model.
module tb_imm_branch_pipe;

    logic clk;
    logic rst;

    imm_branch_pipe_if #(.XLEN(32)) bus ();

    imm_branch_pipe #(
        .XLEN  (32),
        .IMM_W (18),
        .OFF_W (27)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic        in_ready;
        logic        out_valid;
        logic [31:0] immx;
        logic [31:0] bt;
        logic [31:0] ra;
        logic        ovf;
    } obs_t;

    typedef struct {
        logic [31:0] immx;
        logic [31:0] bt;
        logic [31:0] ra;
        logic        ovf;
    } exp_t;

    localparam longint TWO32 = 64'sh1_0000_0000;

    int n_cmp;
    int n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the field values
    function automatic exp_t ref_model(input logic [31:0] p, input logic [31:0] ins, input logic m);
        exp_t   e;
        longint imm;
        longint off;
        longint t;
        longint r;
        if (!m) begin
            imm = longint'(ins[17:0]);
            if (imm >= 64'sd131072) imm = imm - 64'sd262144;
        end else begin
            case (ins[17:16])
                2'b01:   imm = longint'(ins[15:0]);
                2'b10:   imm = longint'(ins[15:0]) * 64'sd65536;
                default: begin
                    imm = longint'(ins[15:0]);
                    if (imm >= 64'sd32768) imm = imm - 64'sd65536;
                end
            endcase
        end
        off = longint'(ins[26:0]);
        if (off >= 64'sd67108864) off = off - 64'sd134217728;
        t = longint'(p) + off * 64'sd4;
        r = longint'(p) + 64'sd4;
        e.immx = 32'(imm);
        e.bt   = 32'(t);
        e.ra   = 32'(r);
        e.ovf  = (t < 64'sd0) || (t >= TWO32) || (r >= TWO32);
        return e;
    endfunction

    task automatic drive(input logic v, input logic [31:0] p, input logic [31:0] i,
                         input logic m, input logic f, input logic r, output obs_t o);
        @(negedge clk);
        bus.in_valid    = v;
        bus.pc          = p;
        bus.instruction = i;
        bus.mode        = m;
        bus.flush       = f;
        bus.out_ready   = r;
        #1;
        o.in_ready  = bus.in_ready;
        o.out_valid = bus.out_valid;
        o.immx      = bus.immx;
        o.bt        = bus.branch_target;
        o.ra        = bus.ret_addr;
`ifdef IMMGEN_OVERFLOW_CHECK_EN
        o.ovf       = bus.target_ovf;
`else
        o.ovf       = 1'b0;
`endif
    endtask

    task automatic test_reset();
        obs_t o;
        drive(1'b1, 32'h0000_0040, 32'h0000_1234, 1'b0, 1'b0, 1'b0, o);
        drive(1'b1, 32'h0000_0080, 32'h0000_5678, 1'b0, 1'b0, 1'b0, o);
        drive(1'b1, 32'h0000_00C0, 32'h0000_9ABC, 1'b0, 1'b0, 1'b0, o);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, o);
        n_cmp++; if (o.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b want=0", o.out_valid); end
        n_cmp++; if (o.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b want=1", o.in_ready); end
        n_cmp++; if (o.immx !== 32'h0) begin n_err++; $display("FAIL reset_immx got=%h want=0", o.immx); end
        n_cmp++; if (o.bt !== 32'h0) begin n_err++; $display("FAIL reset_target got=%h want=0", o.bt); end
        n_cmp++; if (o.ra !== 32'h0) begin n_err++; $display("FAIL reset_ret got=%h want=0", o.ra); end
        n_cmp++; if (o.ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%b want=0", o.ovf); end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, o);
        n_cmp++; if (o.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_no_stale got=%b want=0", o.out_valid); end
    endtask

    task automatic test_legacy();
        obs_t o;
        drive(1'b1, 32'h0, 32'h0003_FFFF, 1'b0, 1'b0, 1'b1, o);
        n_cmp++; if (o.in_ready !== 1'b1) begin n_err++; $display("FAIL legacy_accept got=%b want=1", o.in_ready); end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, o);
        n_cmp++; if (o.out_valid !== 1'b0) begin n_err++; $display("FAIL legacy_lat1 got=%b want=0", o.out_valid); end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, o);
        n_cmp++; if (o.out_valid !== 1'b1) begin n_err++; $display("FAIL legacy_lat2 got=%b want=1", o.out_valid); end
        n_cmp++; if (o.immx !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL legacy_immx got=%h want=ffffffff", o.immx); end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, o);
        n_cmp++; if (o.out_valid !== 1'b0) begin n_err++; $display("FAIL legacy_drain got=%b want=0", o.out_valid); end
    endtask

    task automatic test_modifiers();
        obs_t        o;
        logic [31:0] want [3];
        int          got;
        int          first;
        int          last;
        want[0] = 32'hFFFF_8000;
        want[1] = 32'h0000_8000;
        want[2] = 32'h8000_0000;
        got = 0; first = -1; last = -1;
        for (int c = 0; c < 9; c++) begin
            if (c < 3)
                drive(1'b1, 32'(c * 4), 32'h0000_8000 | (32'(c) << 16), 1'b1, 1'b0, 1'b1, o);
            else
                drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, o);
            if (o.out_valid) begin
                if (got < 3) begin
                    n_cmp++;
                    if (o.immx !== want[got]) begin
                        n_err++; $display("FAIL mod_immx[%0d] got=%h want=%h", got, o.immx, want[got]);
                    end
                end
                if (first < 0) first = c;
                last = c;
                got++;
            end
        end
        n_cmp++; if (got != 3) begin n_err++; $display("FAIL mod_count got=%0d want=3", got); end
        n_cmp++; if (last - first != 2) begin n_err++; $display("FAIL mod_throughput span got=%0d want=2", last - first); end
    endtask

    task automatic test_branch(input logic [31:0] p, input logic [31:0] ins,
                               input logic [31:0] want_bt, input logic [31:0] want_ra, input logic want_ovf);
        obs_t o;
        bit   seen;
        seen = 1'b0;
        drive(1'b1, p, ins, 1'b0, 1'b0, 1'b1, o);
        for (int c = 0; c < 6 && !seen; c++) begin
            drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, o);
            if (o.out_valid) begin
                seen = 1'b1;
                n_cmp++; if (o.bt !== want_bt) begin n_err++; $display("FAIL branch_target pc=%h got=%h want=%h", p, o.bt, want_bt); end
                n_cmp++; if (o.ra !== want_ra) begin n_err++; $display("FAIL ret_addr pc=%h got=%h want=%h", p, o.ra, want_ra); end
`ifdef IMMGEN_OVERFLOW_CHECK_EN
                n_cmp++; if (o.ovf !== want_ovf) begin n_err++; $display("FAIL target_ovf pc=%h got=%b want=%b", p, o.ovf, want_ovf); end
`endif
            end
        end
        n_cmp++; if (!seen) begin n_err++; $display("FAIL branch_timeout pc=%h got=none want=out_valid", p); end
        if (want_ovf === 1'bx) $display("unreachable");
    endtask

    task automatic test_back_to_back();
        obs_t        o;
        exp_t        ea, eb, ec;
        logic [31:0] got_pc [$];
        ea = ref_model(32'h0000_1000, 32'h0123_4567, 1'b0);
        eb = ref_model(32'h0000_2000, 32'h0456_789A, 1'b0);
        ec = ref_model(32'h0000_3000, 32'h07AB_CDEF, 1'b0);
        drive(1'b1, 32'h0000_1000, 32'h0123_4567, 1'b0, 1'b0, 1'b0, o);
        n_cmp++; if (o.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready0 got=%b want=1", o.in_ready); end
        drive(1'b1, 32'h0000_2000, 32'h0456_789A, 1'b0, 1'b0, 1'b0, o);
        n_cmp++; if (o.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready1 got=%b want=1", o.in_ready); end
        for (int c = 2; c < 4; c++) begin
            drive(1'b1, 32'h0000_3000, 32'h07AB_CDEF, 1'b0, 1'b0, 1'b0, o);
            n_cmp++; if (o.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready%0d got=%b want=0", c, o.in_ready); end
            n_cmp++; if (o.out_valid !== 1'b1 || o.bt !== ea.bt || o.immx !== ea.immx) begin
                n_err++; $display("FAIL bp_hold%0d valid=%b bt=%h want valid=1 bt=%h", c, o.out_valid, o.bt, ea.bt);
            end
        end
        drive(1'b1, 32'h0000_3000, 32'h07AB_CDEF, 1'b0, 1'b0, 1'b1, o);
        n_cmp++; if (o.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready4 got=%b want=1", o.in_ready); end
        n_cmp++; if (o.bt !== ea.bt) begin n_err++; $display("FAIL bp_first got=%h want=%h", o.bt, ea.bt); end
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, o);
            if (o.out_valid) got_pc.push_back(o.ra);
        end
        n_cmp++; if (got_pc.size() != 2) begin n_err++; $display("FAIL bp_drain_count got=%0d want=2", got_pc.size()); end
        else begin
            n_cmp++; if (got_pc[0] !== eb.ra || got_pc[1] !== ec.ra) begin
                n_err++; $display("FAIL bp_order got=%h,%h want=%h,%h", got_pc[0], got_pc[1], eb.ra, ec.ra);
            end
        end
    endtask

    task automatic test_flush();
        obs_t o;
        drive(1'b1, 32'h0000_0500, 32'h0000_0011, 1'b0, 1'b0, 1'b0, o);
        drive(1'b1, 32'h0000_0600, 32'h0000_0022, 1'b0, 1'b0, 1'b0, o);
        drive(1'b1, 32'h0000_0700, 32'h0000_0033, 1'b0, 1'b1, 1'b1, o);
        n_cmp++; if (o.in_ready !== 1'b1) begin n_err++; $display("FAIL flush_in_ready got=%b want=1", o.in_ready); end
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, o);
            n_cmp++; if (o.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_stale%0d got=%b want=0", c, o.out_valid); end
        end
    endtask

    task automatic test_random();
        obs_t        o;
        exp_t        q [$];
        exp_t        e;
        logic        v, f, r, m;
        logic [31:0] p, ins;
        for (int c = 0; c < 608; c++) begin
            if (c < 600) begin
                v   = ($urandom_range(0, 9) < 7);
                r   = ($urandom_range(0, 9) < 6);
                f   = ($urandom_range(0, 31) == 0);
                m   = 1'($urandom_range(0, 1));
                p   = $urandom;
                ins = $urandom;
            end else begin
                v = 1'b0; r = 1'b1; f = 1'b0; m = 1'b0; p = 32'h0; ins = 32'h0;
            end
            drive(v, p, ins, m, f, r, o);
            if (f) begin
                n_cmp++; if (o.in_ready !== 1'b1) begin n_err++; $display("FAIL rnd_flush_ready cyc=%0d got=%b want=1", c, o.in_ready); end
            end
            if (o.out_valid && !f) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++; $display("FAIL rnd_spurious cyc=%0d got=out_valid want=idle", c);
                end else if (o.immx !== q[0].immx || o.bt !== q[0].bt || o.ra !== q[0].ra
`ifdef IMMGEN_OVERFLOW_CHECK_EN
                             || o.ovf !== q[0].ovf
`endif
                            ) begin
                    n_err++;
                    $display("FAIL rnd_data cyc=%0d got=%h/%h/%h/%b want=%h/%h/%h/%b",
                             c, o.immx, o.bt, o.ra, o.ovf, q[0].immx, q[0].bt, q[0].ra, q[0].ovf);
                end
                if (r && q.size() != 0) void'(q.pop_front());
            end
            if (f) q.delete();
            else if (v && o.in_ready) begin
                e = ref_model(p, ins, m);
                q.push_back(e);
            end
        end
        n_cmp++; if (q.size() != 0) begin n_err++; $display("FAIL rnd_leftover got=%0d want=0", q.size()); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.pc = '0; bus.instruction = '0;
        bus.mode = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_legacy();
        test_modifiers();
        test_branch(32'h0000_0100, 32'h07FF_FFFF, 32'h0000_00FC, 32'h0000_0104, 1'b0);
        test_branch(32'hFFFF_FFFC, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 1'b1);
        test_branch(32'h0000_0004, 32'h07FF_FFFE, 32'hFFFF_FFFC, 32'h0000_0008, 1'b1);
        test_back_to_back();
        test_flush();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/imm_branch_pipe.md
IMM_BRANCH_PIPE -- requirements
Module: imm_branch_pipe

Interface
REQ-001 The block SHALL have these parameters: XLEN, 32, datapath and PC width; IMM_W, 18, legacy immediate field width; OFF_W, 27, branch offset field width.
REQ-002 Port clk, input, 1, single clock; all state changes on its rising edge.
REQ-003 Port rst, input, 1, synchronous active-high reset.
REQ-004 Port in_valid, input, 1, pc/instruction/mode are valid.
REQ-005 Port in_ready, output, 1, block accepts this cycle.
REQ-006 Port pc, input, XLEN, instruction address.
REQ-007 Port instruction, input, 32, instruction word.
REQ-008 Port mode, input, 1, 0 = legacy (IMM_W-bit sign-extend), 1 = modifier decode.
REQ-009 Port flush, input, 1, discard all in-flight entries.
REQ-010 Port out_valid, output, 1, results valid.
REQ-011 Port out_ready, input, 1, consumer accepts.
REQ-012 Port immx, output, XLEN, extended immediate.
REQ-013 Port branch_target, output, XLEN, pc + (sign-extended offset << 2).
REQ-014 Port ret_addr, output, XLEN, pc + 4.

Function
REQ-015 The block SHALL be a 2-stage pipeline, S1 (extend, latch pc) then S2 (adders, registered outputs); each stage holds one entry with a valid bit.
REQ-016 Transfer SHALL occur when valid and ready are both high; in_ready = !s1_valid | (s1 moves to S2 this cycle); S2 empties when out_valid & out_ready.
REQ-017 Latency SHALL be 2 cycles from accept to out_valid with no backpressure; throughput SHALL be 1 per cycle.
REQ-018 Outputs SHALL hold stable while out_valid & !out_ready.
REQ-019 In legacy mode: immx = sign-extend instruction[IMM_W-1:0] to XLEN.
REQ-020 In modifier mode: imm16 = instruction[15:0], mod = instruction[17:16]; 00 gives sign-extend imm16; 01 gives zero-extend imm16; 10 gives imm16 << 16 with low bits zero; 11 (reserved) gives the same as 00.
REQ-021 branch_target SHALL be pc + (sign-extend instruction[OFF_W-1:0] to XLEN) << 2, truncated to XLEN (wraps modulo 2^XLEN).
REQ-022 ret_addr SHALL be pc + 4, truncated to XLEN.
REQ-023 flush SHALL clear both valid bits on the next edge; an entry offered the same cycle SHALL be dropped and in_ready SHALL read 1.
REQ-024 flush SHALL take priority over simultaneous accept and output handshakes.
REQ-025 Entry order SHALL be preserved under any backpressure pattern.

Reset
REQ-026 When rst=1 at an edge: both valid bits cleared; immx, branch_target, ret_addr = 0; out_valid = 0.
REQ-027 Reset mid-operation SHALL discard all entries; in_ready SHALL be 1 in the first cycle after reset.

Configuration
REQ-028 The macro IMMGEN_OVERFLOW_CHECK_EN, when defined, SHALL add output target_ovf (1 bit, registered with S2, reset 0), set when the branch_target or ret_addr add wraps past 2^XLEN-1 or below 0.
REQ-029 Without IMMGEN_OVERFLOW_CHECK_EN the port SHALL be absent and wrap remains silent.

Structure
REQ-030 Package imm_gen_pkg SHALL hold the mode encoding constants, the modifier encodings (MOD_DEFAULT, MOD_U, MOD_H), and the default parameter values.
REQ-031 A combinational sub-module imm_extend SHALL implement REQ-019/REQ-020, instantiated in S1.

Verification
REQ-032 Legacy: instruction=0x0003FFFF, mode 0 -> immx=0xFFFFFFFF after 2 cycles.
REQ-033 Modifiers: imm16=0x8000 with mod 00/01/10 -> immx 0xFFFF8000 / 0x00008000 / 0x80000000.
REQ-034 Branch: pc=0x00000100, offset field 0x7FFFFFF -> branch_target=0x000000FC, ret_addr=0x00000104.
REQ-035 Backpressure: 3 back-to-back inputs, out_ready low 4 cycles -> in_ready drops after 2 accepted; the outputs then emerge in order; the third is accepted after the first drains.
REQ-036 Flush: flush asserted with both stages full and in_valid high -> out_valid=0 next cycle, no stale output.
REQ-037 Overflow (macro on): pc=0xFFFFFFFC, offset=+1 -> branch_target=0x00000000, target_ovf=1.
